// File: rtl/qspi_pkg.sv
// Shared types and width helpers for the QSPI XIP read path.
// Imported by the byte packer and the prefetch buffer.
package qspi_pkg;

   localparam int QSPI_BYTE_W = 8;

   typedef logic [QSPI_BYTE_W-1:0] qspi_byte_t;

   // Width of an index over n items, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of an occupancy counter that must be able to hold n itself.
   function automatic int level_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/qspi_byte_packer.sv
// Packs flash bytes little-endian into DATA_W words.
// A push is raised on the completing byte or on the last byte of a burst.
module qspi_byte_packer
   import qspi_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              h_clk,
   input  logic              h_rstn,
   input  logic              flush_in,
   input  logic              byte_valid_in,
   input  qspi_byte_t        byte_in,
   input  logic              byte_last_in,
   output logic              push,
   output logic [DATA_W-1:0] push_word
);

   localparam int BPW = DATA_W / QSPI_BYTE_W;
   localparam int LW  = cnt_w(BPW);

   logic [LW-1:0]     lane_cnt;
   logic [DATA_W-1:0] staging;
   logic [DATA_W-1:0] merged;

   // Lanes above the current byte are still zero in staging, which gives
   // the zero-padded partial word at the end of a burst for free.
   always_comb begin
      merged = staging;
      for (int i = 0; i < BPW; i++) begin
         if (lane_cnt == LW'(i)) begin
            merged[i*QSPI_BYTE_W +: QSPI_BYTE_W] = byte_in;
         end
      end
   end

   assign push      = byte_valid_in && !flush_in &&
                      ((lane_cnt == LW'(BPW - 1)) || byte_last_in);
   assign push_word = merged;

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         lane_cnt <= '0;
         staging  <= '0;
      end else if (flush_in) begin
         lane_cnt <= '0;
         staging  <= '0;
      end else if (byte_valid_in) begin
         if (push) begin
            lane_cnt <= '0;
            staging  <= '0;
         end else begin
            lane_cnt <= lane_cnt + LW'(1);
            staging  <= merged;
         end
      end
   end

endmodule

// File: rtl/qspi_rd_prefetch_buf.sv
// XIP read prefetch buffer: byte packer feeding a DEPTH-entry show-ahead FIFO
// with almost-full back-pressure, flush and sticky overflow/underflow flags.
module qspi_rd_prefetch_buf
   import qspi_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                         h_clk,
   input  logic                         h_rstn,
   input  logic                         flush_in,
   input  logic                         byte_valid_in,
   input  logic [QSPI_BYTE_W-1:0]       byte_in,
   input  logic                         byte_last_in,
   input  logic                         rd_en_in,
   output logic [DATA_W-1:0]            rd_data_out,
   output logic                         empty_out,
   output logic                         full_out,
   output logic                         almost_full_out,
   output logic [$clog2(DEPTH+1)-1:0]   level_out,
   output logic                         overflow_out,
   output logic                         underflow_out
);

   localparam int PW  = cnt_w(DEPTH);
   localparam int LVW = level_w(DEPTH);

   logic              push;
   logic [DATA_W-1:0] push_word;

   qspi_byte_packer #(.DATA_W(DATA_W)) u_packer (
      .h_clk         (h_clk),
      .h_rstn        (h_rstn),
      .flush_in      (flush_in),
      .byte_valid_in (byte_valid_in),
      .byte_in       (byte_in),
      .byte_last_in  (byte_last_in),
      .push          (push),
      .push_word     (push_word)
   );

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [LVW-1:0]    level;
   logic [LVW-1:0]    level_nxt;
   logic              do_push;
   logic              do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is only accepted when a pop frees the head slot
   // in the same edge; a pop on an empty FIFO is never accepted.
   always_comb begin
      do_pop    = rd_en_in && !empty_out && !flush_in;
      do_push   = push && (!full_out || do_pop);
      level_nxt = level;
      if (flush_in) begin
         level_nxt = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   level_nxt = level + LVW'(1);
            2'b01:   level_nxt = level - LVW'(1);
            default: level_nxt = level;
         endcase
      end
   end

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         level           <= '0;
         empty_out       <= 1'b1;
         full_out        <= 1'b0;
         almost_full_out <= 1'b0;
         overflow_out    <= 1'b0;
         underflow_out   <= 1'b0;
      end else begin
         level           <= level_nxt;
         empty_out       <= (level_nxt == '0);
         full_out        <= (level_nxt == LVW'(DEPTH));
         almost_full_out <= (level_nxt >= LVW'(AF_LEVEL));
         if (flush_in) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
         end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !do_push)        overflow_out  <= 1'b1;
            if (rd_en_in && empty_out)   underflow_out <= 1'b1;
         end
      end
   end

   // Storage carries no reset; empty_out masks stale contents from the head.
   always_ff @(posedge h_clk) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   assign level_out   = level;
   assign rd_data_out = empty_out ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_qspi_rd_prefetch_buf.sv
// Directed bench for qspi_rd_prefetch_buf: vector table for the packing and
// flush cases, hand-written sequences for fill/overflow, simultaneity and reset.
module tb_qspi_rd_prefetch_buf;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int AF     = 7;

   logic              h_clk = 1'b0;
   logic              h_rstn = 1'b0;
   logic              flush_in = 1'b0;
   logic              byte_valid_in = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_last_in = 1'b0;
   logic              rd_en_in = 1'b0;
   logic [DATA_W-1:0] rd_data_out;
   logic              empty_out;
   logic              full_out;
   logic              almost_full_out;
   logic [3:0]        level_out;
   logic              overflow_out;
   logic              underflow_out;

   int checks = 0;
   int errors = 0;

   qspi_rd_prefetch_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .h_clk           (h_clk),
      .h_rstn          (h_rstn),
      .flush_in        (flush_in),
      .byte_valid_in   (byte_valid_in),
      .byte_in         (byte_in),
      .byte_last_in    (byte_last_in),
      .rd_en_in        (rd_en_in),
      .rd_data_out     (rd_data_out),
      .empty_out       (empty_out),
      .full_out        (full_out),
      .almost_full_out (almost_full_out),
      .level_out       (level_out),
      .overflow_out    (overflow_out),
      .underflow_out   (underflow_out)
   );

   always #5 h_clk = ~h_clk;

   // flags = {empty, full, almost_full, overflow, underflow}
   typedef struct {
      logic              flush;
      logic              bv;
      logic [7:0]        b;
      logic              last;
      logic              rd;
      logic [DATA_W-1:0] exp_data;
      logic [3:0]        exp_level;
      logic [4:0]        exp_flags;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic fl, input logic bv, input logic [7:0] b,
                               input logic last, input logic rd,
                               input logic [DATA_W-1:0] d, input logic [3:0] lv,
                               input logic [4:0] f);
      vec_t v;
      v.flush = fl; v.bv = bv; v.b = b; v.last = last; v.rd = rd;
      v.exp_data = d; v.exp_level = lv; v.exp_flags = f;
      vecs.push_back(v);
   endfunction

   function automatic logic [4:0] flags();
      return {empty_out, full_out, almost_full_out, overflow_out, underflow_out};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic fl, input logic bv, input logic [7:0] b,
                                 input logic last, input logic rd);
      flush_in = fl; byte_valid_in = bv; byte_in = b; byte_last_in = last; rd_en_in = rd;
      @(posedge h_clk);
      #1;
      flush_in = 1'b0; byte_valid_in = 1'b0; byte_last_in = 1'b0; rd_en_in = 1'b0;
   endtask

   // Sends a full word LSB first; rd on the last byte pops in the same cycle.
   task automatic send_word(input logic [31:0] w, input logic rd);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 1'b1, w[i*8 +: 8], 1'b0, (i == 3) ? rd : 1'b0);
      end
   endtask

   function automatic logic [31:0] word_of(input int k);
      logic [7:0] x;
      x = 8'(k);
      return {x, x, x, x};
   endfunction

   initial begin
      // Reset, fill/drain, underflow then flush
      add(0,0,8'h00,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'h11,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'h22,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'h33,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'h44,0,0, 32'h44332211, 1, 5'b00000);
      add(0,0,8'h00,0,1, 32'h0,        0, 5'b10000);
      add(0,0,8'h00,0,1, 32'h0,        0, 5'b10001);
      add(1,0,8'h00,0,0, 32'h0,        0, 5'b10000);
      // Partial word then a fresh word packing from lane 0
      add(0,1,8'hAA,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'hBB,1,0, 32'h0000BBAA, 1, 5'b00000);
      add(0,1,8'h01,0,0, 32'h0000BBAA, 1, 5'b00000);
      add(0,1,8'h02,0,0, 32'h0000BBAA, 1, 5'b00000);
      add(0,1,8'h03,0,0, 32'h0000BBAA, 1, 5'b00000);
      add(0,1,8'h04,0,0, 32'h0000BBAA, 2, 5'b00000);
      add(0,0,8'h00,0,1, 32'h04030201, 1, 5'b00000);
      add(0,0,8'h00,0,1, 32'h0,        0, 5'b10000);
      // Flush mid-word: three words, two stray bytes, flush with rd_en
      for (int i = 0; i < 12; i++) begin
         add(0,1,8'(8'h10 + i),0,0, (i < 3) ? 32'h0 : 32'h13121110,
             4'((i + 1) / 4), (i < 3) ? 5'b10000 : 5'b00000);
      end
      add(0,1,8'h55,0,0, 32'h13121110, 3, 5'b00000);
      add(0,1,8'h66,0,0, 32'h13121110, 3, 5'b00000);
      add(1,0,8'h00,0,1, 32'h0,        0, 5'b10000);
      add(0,1,8'hC1,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'hC2,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'hC3,0,0, 32'h0,        0, 5'b10000);
      add(0,1,8'hC4,0,0, 32'hC4C3C2C1, 1, 5'b00000);
      add(0,0,8'h00,0,1, 32'h0,        0, 5'b10000);

      #12 h_rstn = 1'b1;
      @(posedge h_clk);
      #1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].flush, vecs[i].bv, vecs[i].b, vecs[i].last, vecs[i].rd);
         check_output($sformatf("vec%0d data", i),  64'(rd_data_out), 64'(vecs[i].exp_data));
         check_output($sformatf("vec%0d level", i), 64'(level_out),   64'(vecs[i].exp_level));
         check_output($sformatf("vec%0d flags", i), 64'(flags()),     64'(vecs[i].exp_flags));
      end

      // Fill to almost-full, full, then overflow with no pop
      for (int k = 1; k <= 7; k++) send_word(word_of(k), 1'b0);
      check_output("af level", 64'(level_out), 64'd7);
      check_output("af flags", 64'(flags()), 64'(5'b00100));
      send_word(word_of(8), 1'b0);
      check_output("full flags", 64'(flags()), 64'(5'b01100));
      send_word(word_of(9), 1'b0);
      check_output("ovf flags", 64'(flags()), 64'(5'b01110));
      check_output("ovf level", 64'(level_out), 64'd8);
      check_output("ovf head", 64'(rd_data_out), 64'(word_of(1)));

      // Push and pop together while full
      send_word(word_of(10), 1'b1);
      check_output("full pp level", 64'(level_out), 64'd8);
      check_output("full pp head", 64'(rd_data_out), 64'(word_of(2)));

      // Drain in order; word 9 was dropped
      for (int k = 0; k < 8; k++) begin
         check_output($sformatf("drain%0d head", k), 64'(rd_data_out),
                      64'(word_of((k < 7) ? k + 2 : 10)));
         apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      end
      check_output("drain level", 64'(level_out), 64'd0);
      check_output("drain flags", 64'(flags()), 64'(5'b10010));

      // Push and pop together while empty
      send_word(32'hDEADBEEF, 1'b1);
      check_output("empty pp level", 64'(level_out), 64'd1);
      check_output("empty pp flags", 64'(flags()), 64'(5'b00011));
      check_output("empty pp head", 64'(rd_data_out), 64'hDEADBEEF);

      // Asynchronous reset between edges with level 5 and sticky flags set
      for (int k = 1; k <= 4; k++) send_word(word_of(k + 32), 1'b0);
      check_output("pre-reset level", 64'(level_out), 64'd5);
      #2 h_rstn = 1'b0;
      #1;
      check_output("async rst level", 64'(level_out), 64'd0);
      check_output("async rst flags", 64'(flags()), 64'(5'b10000));
      check_output("async rst data", 64'(rd_data_out), 64'h0);
      #1 h_rstn = 1'b1;
      @(posedge h_clk);
      #1;
      send_word(32'hCAFEF00D, 1'b0);
      check_output("post-rst level", 64'(level_out), 64'd1);
      check_output("post-rst head", 64'(rd_data_out), 64'hCAFEF00D);
      check_output("post-rst flags", 64'(flags()), 64'(5'b00000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qspi_rd_prefetch_buf.md
Name: qspi_rd_prefetch_buf

Overview:
- Parametrised successor to the fixed 32-bit XIP read buffer. It sits between the QSPI data-sample register and the AHB read-data path.
- Packs flash bytes (little-endian, first byte received in lane 0) into DATA_W words and queues them in a DEPTH-entry show-ahead FIFO.
- Adds three things the old buffer lacked: an almost-full level for QSPI sclk back-pressure, a partial-word push at the end of a burst, and a flush for aborted or redirected XIP sequences.
- Also adds sticky overflow and underflow error flags.

Parameters:
- DATA_W, 32: AHB word width in bits; must be a multiple of 8, from 8 to 64.
- DEPTH, 8: number of FIFO entries, from 2 to 32; need not be a power of two.
- AF_LEVEL, DEPTH-1: level at or above which almost_full_out is asserted; range 1 to DEPTH.

Ports:
- h_clk  in  1  system clock; all logic is on the rising edge.
- h_rstn  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous clear of the FIFO, the packer and the sticky flags.
- byte_valid_in  in  1  byte_in is valid this cycle.
- byte_in  in  8  sampled flash byte.
- byte_last_in  in  1  qualified by byte_valid_in; marks the last byte of a burst and forces a push.
- rd_en_in  in  1  pop request from the AHB side.
- rd_data_out  out  DATA_W  head entry (show-ahead).
- empty_out  out  1  level == 0.
- full_out  out  1  level == DEPTH.
- almost_full_out  out  1  level >= AF_LEVEL.
- level_out  out  $clog2(DEPTH+1)  number of occupied entries.
- overflow_out  out  1  sticky: a word was dropped because the FIFO was full.
- underflow_out  out  1  sticky: rd_en_in was asserted while empty.

Behaviour:
- Reset (asynchronous, h_rstn=0):
  - rd_ptr, wr_ptr, level, packer lane count and staging register all go to 0.
  - empty_out=1; full_out=0; almost_full_out=0; level_out=0; overflow_out=0; underflow_out=0; rd_data_out=0.
- Packer:
  - BPW = DATA_W/8. lane_cnt counts 0..BPW-1.
  - On byte_valid_in, byte_in goes into lane lane_cnt of the staging register, and lane_cnt increments.
  - A push is raised when byte_valid_in is set and either lane_cnt == BPW-1 or byte_last_in is set. The pushed word is the staging contents plus the current byte. Lanes above the current byte are zero in a partial word.
  - A push clears lane_cnt and the staging register in the same edge.
  - Push latency: the word is visible at rd_data_out (if the FIFO was empty) and counted in level_out one cycle after the completing byte. There is no combinational fall-through.
- FIFO:
  - Register array; rd_data_out = mem[rd_ptr] when not empty, otherwise 0.
  - Both pointers wrap explicitly from DEPTH-1 to 0.
  - Pop: rd_en_in && !empty_out advances rd_ptr and decrements level.
- Boundary cases:
  - Push while full with no pop: the word is dropped, overflow_out is set (sticky), and the pointers are unchanged.
  - Push and pop together while full: both are accepted; level stays DEPTH.
  - Push and pop together while empty: the push is accepted, the pop is an underflow, and level goes to 1.
  - Pop while empty: underflow_out is set (sticky); no pointer change.
  - Push and pop together otherwise: level is unchanged and both pointers advance.
- Flush:
  - flush_in dominates any same-cycle push, pop or byte.
  - One edge later: pointers, level, lane_cnt, staging register, overflow_out and underflow_out are all 0, and empty_out=1.
- Status outputs are registered from the next-state level, so they are valid in the same cycle as level_out.

Decomposition:
- Shared package qspi_pkg holds:
  - typedef for a flash byte (8 bits);
  - function clog2-based width helpers;
  - constant QSPI_BYTE_W=8.
- One natural sub-module: qspi_byte_packer. It contains lane_cnt, the staging register and push generation, and outputs push/push_word.
- The FIFO storage and pointer logic stay in qspi_rd_prefetch_buf.

Test Plan:
- Fill and drain (DATA_W=32, DEPTH=8): send bytes 0x11,0x22,0x33,0x44. One cycle after 0x44, expect rd_data_out=0x44332211, level_out=1, empty_out=0. Then rd_en_in for 1 cycle: expect empty_out=1, level_out=0.
- Partial word: send 0xAA, then 0xBB with byte_last_in=1. Expect head=0x0000BBAA. Then send 4 further bytes 0x01..0x04: they pack from lane 0, expect second word 0x04030201.
- Full and overflow (DEPTH=8, AF_LEVEL=7): push 7 words, expect almost_full_out=1 and full_out=0. Push an 8th, expect full_out=1. Push a 9th with no pop: expect overflow_out=1 and level_out=8, and head still equals the 1st word.
- Simultaneous events: when full, push and pop in the same cycle: expect level_out=8 and head = 2nd word. When empty, push and pop in the same cycle: expect underflow_out=1 and level_out=1.
- Flush mid-word: push 3 words, send 2 bytes, assert flush_in together with rd_en_in. Expect level_out=0, flags=0, empty_out=1. Then 4 new bytes produce exactly one word, with no leftover bytes.
- Reset mid-operation: drop h_rstn asynchronously between clock edges with level_out=5. Outputs reach reset values before the next edge, and normal operation resumes after release.
